// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 flash read responder (0x03 / 0x0B) over a byte memory
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   spi_cs            chip select from initiator, active low
//   spi_sclk          SPI clock, mode 0
//   spi_mosi          initiator data, sampled on sclk rising edge
//   spi_miso          read data, MSB first, updated on sclk falling edge (0 when not driven)
//   spi_miso_oe       high only while driving read data
//   mem_re            one-cycle read strobe, mem_addr valid in the same cycle
//   mem_addr          backing-memory byte address
//   mem_rdata         memory data, valid one clk after mem_re
//   busy              transaction in progress
//   cmd_err           one-cycle pulse when an unsupported opcode completes
module spi_flash_responder #(
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DUMMY  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_IGNORE = 3'd5;

  localparam int SW = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic                   cs_q, sclk_q;
  logic [SW-1:0]          settle_cnt;
  logic [2:0]             state;
  logic [4:0]             bit_cnt;
  logic [22:0]            sr;
  logic                   dummy;
  logic [2:0]             tx_cnt;
  logic [7:0]             tx_sr;
  logic [7:0]             pre_byte;
  logic                   miso_q;
  logic                   re_q;

  logic cs_s, sclk_s, mosi_s;
  logic settled, cs_fall, sclk_rise, sclk_fall;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // The synchronizers come out of reset showing cs high. If cs is really
  // held low, that reset value would flush through and look like a falling
  // edge, so edges are ignored until the pipeline holds only real samples.
  assign settled   = (settle_cnt == SW'(SYNC_STAGES + 1));
  assign cs_fall   = settled & cs_q & ~cs_s;
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;

  assign busy        = (state != S_IDLE);
  assign spi_miso_oe = (state == S_DATA) & ~cs_s;
  assign spi_miso    = spi_miso_oe & miso_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync    <= '1;
      sclk_sync  <= '0;
      mosi_sync  <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      settle_cnt <= '0;
      state      <= S_IDLE;
      bit_cnt    <= '0;
      sr         <= '0;
      dummy      <= 1'b0;
      tx_cnt     <= '0;
      tx_sr      <= '0;
      pre_byte   <= '0;
      miso_q     <= 1'b0;
      re_q       <= 1'b0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
      cmd_err    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_q      <= cs_s;
      sclk_q    <= sclk_s;
      if (!settled) settle_cnt <= settle_cnt + SW'(1);

      mem_re  <= 1'b0;
      cmd_err <= 1'b0;
      re_q    <= mem_re;
      // Prefetched byte parks here until the next byte boundary so the
      // byte currently shifting out is never disturbed.
      if (re_q) pre_byte <= mem_rdata;

      // cs deassertion wins over any sclk edge in the same cycle.
      if (state != S_IDLE && cs_s) begin
        state   <= S_IDLE;
        bit_cnt <= '0;
        sr      <= '0;
        dummy   <= 1'b0;
        tx_cnt  <= '0;
        miso_q  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cs_fall) begin
              state   <= S_CMD;
              bit_cnt <= '0;
              sr      <= '0;
              dummy   <= 1'b0;
            end
          end
          S_CMD: begin
            if (sclk_rise) begin
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                sr      <= '0;
                if ({sr[6:0], mosi_s} == 8'h03) begin
                  state <= S_ADDR;
                  dummy <= 1'b0;
                end else if ({sr[6:0], mosi_s} == 8'h0B) begin
                  state <= S_ADDR;
                  dummy <= 1'b1;
                end else begin
                  state   <= S_IGNORE;
                  cmd_err <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                sr      <= {sr[21:0], mosi_s};
              end
            end
          end
          S_ADDR: begin
            if (sclk_rise) begin
              if (bit_cnt == 5'd23) begin
                bit_cnt  <= '0;
                mem_addr <= ADDR_W'({sr, mosi_s});
                mem_re   <= 1'b1;
                tx_cnt   <= '0;
                miso_q   <= 1'b0;
                state    <= dummy ? S_DUMMY : S_DATA;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                sr      <= {sr[21:0], mosi_s};
              end
            end
          end
          S_DUMMY: begin
            if (sclk_rise) begin
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                state   <= S_DATA;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          S_DATA: begin
            if (sclk_fall) begin
              tx_cnt <= tx_cnt + 3'd1;
              if (tx_cnt == 3'd0) begin
                // Byte boundary: drive bit 7 and fetch the following byte.
                miso_q   <= pre_byte[7];
                tx_sr    <= {pre_byte[6:0], 1'b0};
                mem_addr <= mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                mem_re   <= 1'b1;
              end else begin
                miso_q <= tx_sr[7];
                tx_sr  <= {tx_sr[6:0], 1'b0};
              end
            end
          end
          S_IGNORE: begin
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - directed scoreboard bench for spi_flash_responder
module tb_spi_flash_responder;

  localparam int H = 8;  // clk cycles per sclk half period

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_cs;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        mem_re;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;
  logic        cmd_err;

  spi_flash_responder #(.ADDR_W(16), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_cs      (spi_cs),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .mem_re      (mem_re),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];

  int   vectors     = 0;
  int   miscompares = 0;
  int   re_total    = 0;
  int   err_total   = 0;
  int   re_double   = 0;
  logic re_prev     = 1'b0;
  int   oe_ones     = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    re_prev <= mem_re;
    if (mem_re) re_total <= re_total + 1;
    if (mem_re && re_prev) re_double <= re_double + 1;
    if (cmd_err) err_total <= err_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shifts the top n bits of tx out MSB first; miso is sampled just before
  // each rising edge, as a mode-0 initiator would.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = tx[i];
      repeat (H) @(negedge clk);
      rx[i] = spi_miso;
      if (spi_miso_oe) oe_ones++;
      spi_sclk = 1'b1;
      repeat (H) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx);
    logic [7:0] rx;
    spi_bits(tx, 8, rx);
  endtask

  task automatic header(input logic [7:0] op, input logic [23:0] addr);
    xfer(op);
    xfer(addr[23:16]);
    xfer(addr[15:8]);
    xfer(addr[7:0]);
  endtask

  task automatic read_byte(input string tag);
    logic [7:0] rx;
    spi_bits(8'h00, 8, rx);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed %0h expected none queued", tag, rx);
    end else begin
      check(tag, {24'h0, rx}, {24'h0, exp_q.pop_front()});
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (H) @(negedge clk);
    spi_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int re0;
    int e0;
    logic [7:0] junk;

    rst      = 1'b1;
    spi_cs   = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_miso", spi_miso, 0);
    check("rst_oe", spi_miso_oe, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    mem[16'h0010] = 8'hA5;
    mem[16'h0011] = 8'h3C;
    mem[16'hFFFF] = 8'h11;
    mem[16'h0000] = 8'h22;

    // Plain read, two bytes. Fetches: one at address exit plus one at the
    // start of every byte the initiator clocks into (the trailing falling
    // edge of each byte opens the next), so 2 + data bytes strobes.
    re0 = re_total;
    cs_low();
    check("t1_busy", busy, 1);
    oe_ones = 0;
    header(8'h03, 24'h000010);
    check("t1_hdr_oe", oe_ones, 0);
    oe_ones = 0;
    exp_q.push_back(mem[16'h0010]);
    exp_q.push_back(mem[16'h0011]);
    read_byte("t1_byte0");
    read_byte("t1_byte1");
    check("t1_data_oe", oe_ones, 16);
    cs_high();
    check("t1_idle_busy", busy, 0);
    check("t1_idle_oe", spi_miso_oe, 0);
    check("t1_mem_re", re_total - re0, 4);

    // Fast read with dummy byte.
    re0 = re_total;
    cs_low();
    oe_ones = 0;
    header(8'h0B, 24'h000010);
    xfer(8'h00);
    check("t2_dummy_oe", oe_ones, 0);
    oe_ones = 0;
    exp_q.push_back(mem[16'h0010]);
    read_byte("t2_byte0");
    check("t2_data_oe", oe_ones, 8);
    cs_high();
    check("t2_mem_re", re_total - re0, 3);

    // Unsupported opcode.
    re0 = re_total;
    e0  = err_total;
    cs_low();
    oe_ones = 0;
    xfer(8'h9F);
    xfer(8'h00);
    xfer(8'h00);
    check("t3_ignore_busy", busy, 1);
    cs_high();
    check("t3_cmd_err", err_total - e0, 1);
    check("t3_oe", oe_ones, 0);
    check("t3_mem_re", re_total - re0, 0);

    // Aborted after 12 address bits, then a clean read of 0x0011.
    cs_low();
    xfer(8'h03);
    xfer(8'h00);
    spi_bits(8'h00, 4, junk);
    cs_high();
    check("t4_abort_busy", busy, 0);
    cs_low();
    header(8'h03, 24'h000011);
    exp_q.push_back(mem[16'h0011]);
    read_byte("t4_byte0");
    cs_high();

    // Address wrap at the top of memory.
    cs_low();
    header(8'h03, 24'h00FFFF);
    exp_q.push_back(mem[16'hFFFF]);
    exp_q.push_back(mem[16'h0000]);
    read_byte("t5_byte0");
    read_byte("t5_byte1");
    cs_high();

    // Reset mid-DATA with cs held low.
    cs_low();
    header(8'h03, 24'h000010);
    exp_q.push_back(mem[16'h0010]);
    read_byte("t6_byte0");
    spi_bits(8'h00, 3, junk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_rst_miso", spi_miso, 0);
    check("t6_rst_oe", spi_miso_oe, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_mem_addr", mem_addr, 0);
    check("t6_rst_mem_re", mem_re, 0);
    rst = 1'b0;
    re0 = re_total;
    oe_ones = 0;
    header(8'h03, 24'h000010);
    xfer(8'h00);
    xfer(8'h00);
    check("t6_held_mem_re", re_total - re0, 0);
    check("t6_held_busy", busy, 0);
    check("t6_held_oe", oe_ones, 0);
    cs_high();
    cs_low();
    header(8'h03, 24'h000011);
    exp_q.push_back(mem[16'h0011]);
    read_byte("t6_after_byte0");
    cs_high();

    check("re_single_cycle", re_double, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 Parameter ADDR_W, default 16: width of backing-memory byte address; SPI address bits above ADDR_W are ignored.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on spi_cs, spi_sclk, spi_mosi.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 spi_cs  input  1  chip select from initiator, active low.
REQ-006 spi_sclk  input  1  SPI clock, mode 0 (idle low).
REQ-007 spi_mosi  input  1  initiator data (IO0), sampled on sclk rising edge.
REQ-008 spi_miso  output  1  responder data (IO1), updated on sclk falling edge, MSB first.
REQ-009 spi_miso_oe  output  1  high only while driving read data.
REQ-010 mem_re  output  1  one-cycle read strobe to backing memory.
REQ-011 mem_addr  output  ADDR_W  byte address for mem_re.
REQ-012 mem_rdata  input  8  memory data, valid exactly one clk after mem_re.
REQ-013 busy  output  1  high while a transaction is in progress (cs low after sync).
REQ-014 cmd_err  output  1  one-cycle pulse when an unsupported opcode completes.

Function
REQ-015 spi_cs/sclk/mosi shall pass through SYNC_STAGES flops; sclk edges detected on synchronized value; clk shall be >= 8x sclk frequency.
REQ-016 States: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
REQ-017 IDLE -> CMD on synchronized cs falling; bit counter cleared.
REQ-018 CMD: shift 8 mosi bits MSB first; after bit 8, opcode 0x03 -> ADDR, 0x0B -> ADDR with dummy flag set, any other -> IGNORE with cmd_err pulse.
REQ-019 ADDR: shift 24 bits MSB first; on 24th rising edge, go to DUMMY if dummy flag else DATA, and issue mem_re with mem_addr = addr[ADDR_W-1:0] in same cycle.
REQ-020 DUMMY: count 8 sclk rising edges, mosi ignored, then DATA; fetch issued at ADDR exit stays latched.
REQ-021 DATA: byte loaded into tx shift register one clk after mem_re; first bit (bit 7) driven on next sclk falling edge; each later falling edge shifts out next bit.
REQ-022 DATA: on the falling edge driving bit 7 of byte N, address increments and mem_re issued for byte N+1; loaded at falling edge after bit 0 of byte N sampled, so stream is gapless.
REQ-023 Address increments modulo 2^ADDR_W (0xFFFF -> 0x0000 at default).
REQ-024 spi_miso_oe = 1 only in DATA with cs low; spi_miso = 0 whenever oe = 0.
REQ-025 IGNORE: no mem_re, oe = 0, remain until cs high.
REQ-026 cs rising (synchronized) in any state -> IDLE next clk, oe = 0, partial shift/count state discarded; takes priority over simultaneous sclk edge.
REQ-027 busy = 1 in every state except IDLE.
REQ-028 mem_re at most one cycle per byte; never asserted outside ADDR exit or DATA.

Reset
REQ-029 rst high: state IDLE; spi_miso, spi_miso_oe, mem_re, busy, cmd_err = 0; mem_addr = 0; shift registers, counters, dummy flag cleared; synchronizers set to cs = 1, sclk = 0, mosi = 0.
REQ-030 rst asserted mid-transaction aborts it; after release, responder waits for fresh cs falling edge (cs already low is not a new transaction).

Verification
REQ-031 mem[0x0010]=0xA5, mem[0x0011]=0x3C; cs low, send 0x03 0x00 0x00 0x10, 16 clocks -> miso bytes 0xA5, 0x3C; oe high only during those 16 bits.
REQ-032 Same memory, send 0x0B 0x00 0x00 0x10 + 8 dummy clocks, 8 clocks -> 0xA5; oe low during dummy phase.
REQ-033 Send 0x9F, 16 more clocks -> cmd_err pulses once, oe stays 0, no mem_re.
REQ-034 cs high after 12 address bits, then valid 0x03 read of 0x0011 -> first returned byte 0x3C.
REQ-035 mem[0xFFFF]=0x11, mem[0x0000]=0x22; read from 0x00FFFF for 16 clocks -> 0x11, 0x22.
REQ-036 rst pulsed mid-DATA with cs held low -> outputs at reset values, no further mem_re until cs high then low.
